serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial N-bit adder that consumes operands LSB-first through one full-adder cell built from two halfadder instances plus an OR gate.
- A registered carry flip-flop links successive bits.
- Sits downstream of operand sources and reuses the existing halfadder cell as its arithmetic core.
- Trades latency (WIDTH cycles) for area; presents a start/busy/done handshake to the controlling logic.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request to begin an addition; sampled only in IDLE
- a  input  WIDTH  operand A; captured on the accepted start cycle
- b  input  WIDTH  operand B; captured on the accepted start cycle
- busy  output  1  high while an addition is in progress (SHIFT state)
- done  output  1  one-cycle pulse; sum/carry are valid from this cycle
- sum  output  WIDTH  registered result, low WIDTH bits of a+b
- carry  output  1  registered carry-out of a+b

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst); it is sampled on the clk rising edge only.
- Reset values: state=IDLE, busy=0, done=0, sum=0, carry=0; internal shift registers, carry flip-flop and bit counter all 0.
- States: IDLE, SHIFT, DONE. Encoding is in the package.
- IDLE:
  - busy=0, done=0.
  - If start=1: load a into shift register sa, b into sb, clear carry flip-flop cff=0, clear counter cnt=0, go to SHIFT.
  - If start=0: stay in IDLE.
- SHIFT, each cycle:
  - Full-adder cell computes s = sa[0]^sb[0]^cff and co = (sa[0]&sb[0]) | ((sa[0]^sb[0])&cff).
  - Result shift register sr shifts right with s entering at MSB. sa and sb shift right with 0 fill. cff<=co. cnt<=cnt+1.
  - When cnt==WIDTH-1 (the last bit processed this cycle), go to DONE.
- DONE:
  - sum<=sr, carry<=cff, both taking their final values from this cycle.
  - done=1 for exactly this cycle. Next state is IDLE unconditionally.
- Latency: start accepted at edge k -> busy high in cycles k+1..k+WIDTH -> done high in cycle k+WIDTH+1, with sum/carry valid on its outputs in that same cycle. Next start is accepted in IDLE at cycle k+WIDTH+2 at the earliest.
- sum/carry hold their last result until the next DONE. They do not change during SHIFT.
- start while busy or done: ignored, with no effect on operands or result.
- a/b changing after the accepted start: no effect (operands are captured).
- Reset mid-operation: abort and return to the reset values above. The next start begins a fresh addition.
- Counter width is $clog2(WIDTH+1). There is no wrap-around, since the counter is cleared on each accepted start.
- WIDTH=1 edge case: one SHIFT cycle, then DONE. Latency is 2 cycles from start to done.
- Arithmetic is unsigned, with no overflow flag other than carry.
- Simultaneous rst and start: rst wins.

Decomposition:
- Package serial_adder_pkg:
  - state localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2
  - function for counter width
- Sub-module fa_cell:
  - Two halfadder instances (ha0: a,b -> s0,c0; ha1: s0,cin -> sum,c1) plus cout=c0|c1.
  - Purely combinational; instantiated once in serial_adder.
- Top-level holds the FSM, shift registers, cff, counter and output registers.

Test Plan:
- rst=1 for 2 cycles, then release -> busy=0, done=0, sum=8'h00, carry=0; a=8'h00, b=8'h00, start pulse -> done in cycle 9 after start, sum=8'h00, carry=0.
- a=8'h5A, b=8'h3C, start -> busy high for 8 cycles, done pulses once, sum=8'h96, carry=0.
- a=8'hFF, b=8'h01 -> sum=8'h00, carry=1; a=8'hFF, b=8'hFF -> sum=8'hFE, carry=1 (back-to-back runs, start reasserted the cycle after done).
- a=8'h12, b=8'h34 started, then start pulsed with a=8'hFF, b=8'hFF at busy cycle 3 -> ignored; result sum=8'h46, carry=0; sum holds the previous value throughout SHIFT.
- Start a=8'hAA, b=8'h55; rst=1 in busy cycle 4 -> next cycle busy=0, sum=0, carry=0, done never pulses; new start with a=8'h01, b=8'h01 -> sum=8'h02.
- WIDTH=1 instance: a=1, b=1 -> done 2 cycles after start, sum=1'b0, carry=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder.
// State encoding and counter sizing helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Bits needed to hold a count of 0..w
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/halfadder.sv
// Single-bit half adder cell.
// Ports: a, b in; s (sum), c (carry) out.
module halfadder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder_fa_cell.sv
// Full adder built from two half adders and an OR.
// Ports: a, b, cin in; sum, cout out. Combinational.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic s0;
  logic c0;
  logic c1;

  halfadder ha0 (
    .a (a),
    .b (b),
    .s (s0),
    .c (c0)
  );

  halfadder ha1 (
    .a (s0),
    .b (cin),
    .s (sum),
    .c (c1)
  );

  assign cout = c0 | c1;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit unsigned adder, LSB first.
// Ports: clk, rst, start, a, b in; busy, done, sum, carry out.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic [WIDTH:0]   sr_cat;
  logic [CW-1:0]    cnt;
  logic             cff;
  logic             s;
  logic             co;
  logic             last;

  fa_cell u_fa (
    .a    (sa[0]),
    .b    (sb[0]),
    .cin  (cff),
    .sum  (s),
    .cout (co)
  );

  // New bit enters at the MSB; works for WIDTH=1
  assign sr_cat = {s, sr};
  assign last   = (cnt == LAST);

  assign busy = (state == ST_SHIFT);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Result is captured on the edge that finishes the last
  // bit, so sum/carry already show it while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      cff   <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            cff <= 1'b0;
            cnt <= '0;
          end
        end
        ST_SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sr  <= sr_cat[WIDTH:1];
          cff <= co;
          cnt <= cnt + CW'(1);
          if (last) begin
            sum   <= sr_cat[WIDTH:1];
            carry <= co;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder.
// Covers WIDTH=8 and WIDTH=1 instances.
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       carry;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       busy1;
  logic       done1;
  logic [0:0] sum1;
  logic       carry1;

  int nvec;
  int nerr;

  logic [7:0] last_sum;
  logic       last_carry;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       c;
  } vec_t;

  vec_t tbl [8];

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .carry (carry1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle.
  // inj: busy cycle where a stray start is pulsed (0=none)
  // rcyc: busy cycle where reset is asserted (0=none)
  task automatic run8(input logic [7:0] x,
                      input logic [7:0] y,
                      input logic [7:0] es,
                      input logic       ec,
                      input int         inj,
                      input int         rcyc);
    a = x;
    b = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    for (int i = 1; i <= 8; i++) begin
      chk("busy_hi", busy, 1);
      chk("done_lo_shift", done, 0);
      chk("sum_hold", sum, last_sum);
      chk("carry_hold", carry, last_carry);
      if (i == inj) begin
        start = 1'b1;
        a = 8'hFF;
        b = 8'hFF;
      end else begin
        start = 1'b0;
      end
      if (i == rcyc) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_carry", carry, 0);
        last_sum = 8'h00;
        last_carry = 1'b0;
        for (int j = 0; j < 10; j++) begin
          @(negedge clk);
          chk("no_done_after_rst", done, 0);
        end
        return;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_hi", done, 1);
    chk("busy_lo_done", busy, 0);
    chk("sum", sum, es);
    chk("carry", carry, ec);
    last_sum = es;
    last_carry = ec;
    @(negedge clk);
    chk("done_pulse_end", done, 0);
    chk("busy_idle", busy, 0);
    chk("sum_keep", sum, es);
    chk("carry_keep", carry, ec);
  endtask

  task automatic run1(input logic x, input logic y);
    logic [1:0] t;
    t = {1'b0, x} + {1'b0, y};
    a1 = x;
    b1 = y;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("w1_busy", busy1, 1);
    chk("w1_done_lo", done1, 0);
    @(negedge clk);
    chk("w1_done", done1, 1);
    chk("w1_sum", sum1, t[0]);
    chk("w1_carry", carry1, t[1]);
    @(negedge clk);
    chk("w1_done_end", done1, 0);
    chk("w1_busy_end", busy1, 0);
  endtask

  initial begin
    logic [8:0] m;
    logic [7:0] x;
    logic [7:0] y;
    nvec = 0;
    nerr = 0;
    rst = 1'b1;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    start1 = 1'b0;
    a1 = 1'b0;
    b1 = 1'b0;
    last_sum = 8'h00;
    last_carry = 1'b0;

    tbl[0] = '{8'h00, 8'h00, 8'h00, 1'b0};
    tbl[1] = '{8'h5A, 8'h3C, 8'h96, 1'b0};
    tbl[2] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    tbl[3] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    tbl[4] = '{8'h80, 8'h80, 8'h00, 1'b1};
    tbl[5] = '{8'h7F, 8'h01, 8'h80, 1'b0};
    tbl[6] = '{8'h01, 8'h01, 8'h02, 1'b0};
    tbl[7] = '{8'hA5, 8'h5A, 8'hFF, 1'b0};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_sum", sum, 0);
    chk("reset_carry", carry, 0);
    chk("reset_w1_busy", busy1, 0);
    chk("reset_w1_done", done1, 0);

    // Back-to-back table runs
    for (int i = 0; i < 8; i++) begin
      run8(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].c, 0, 0);
    end

    // Stray start during busy cycle 3
    run8(8'h12, 8'h34, 8'h46, 1'b0, 3, 0);

    // Reset in busy cycle 4 aborts, then fresh add
    run8(8'hAA, 8'h55, 8'hFF, 1'b0, 0, 4);
    run8(8'h01, 8'h01, 8'h02, 1'b0, 0, 0);

    // Random operands against plain arithmetic
    for (int i = 0; i < 24; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      m = {1'b0, x} + {1'b0, y};
      run8(x, y, m[7:0], m[8], 0, 0);
    end

    // WIDTH=1 instance
    run1(1'b1, 1'b1);
    run1(1'b0, 1'b0);
    run1(1'b1, 1'b0);
    run1(1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
